// File: rtl/control_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, state encoding,
// mux-select constants and the bundled control-word type.
package control_pkg;

  localparam int OPCODE_W = 5;
  localparam int STATE_W  = 5;

  // Supported opcodes (instruction bits [4:0])
  localparam logic [4:0] OP_MOVESP = 5'h19;
  localparam logic [4:0] OP_INPUT  = 5'h1A;
  localparam logic [4:0] OP_JAL    = 5'h14;
  localparam logic [4:0] OP_LOADSP = 5'h1F;
  localparam logic [4:0] OP_ADDI   = 5'h18;
  localparam logic [4:0] OP_SWAP   = 5'h0B;
  localparam logic [4:0] OP_JB     = 5'h1D;
  localparam logic [4:0] OP_OUTPUT = 5'h1C;

  // Mux-select constants
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_FUNC  = 2'b10;
  localparam logic [1:0] IORD_PC     = 2'b00;
  localparam logic [1:0] IORD_MDR    = 2'b01;
  localparam logic [1:0] IORD_ALUOUT = 2'b10;
  localparam logic [1:0] IORD_SP     = 2'b11;

  // State encoding; codes 26..31 are unused and recover to FETCH
  typedef enum logic [STATE_W-1:0] {
    ST_INIT    = 5'd0,
    ST_FETCH   = 5'd1,
    ST_DECODE  = 5'd2,
    ST_MS1     = 5'd3,
    ST_MS2     = 5'd4,
    ST_IN1     = 5'd5,
    ST_IN2     = 5'd6,
    ST_J1      = 5'd7,
    ST_J2      = 5'd8,
    ST_J3      = 5'd9,
    ST_J4      = 5'd10,
    ST_J5      = 5'd11,
    ST_L1      = 5'd12,
    ST_L2      = 5'd13,
    ST_L3      = 5'd14,
    ST_AD1     = 5'd15,
    ST_AD2     = 5'd16,
    ST_SW1     = 5'd17,
    ST_SW2     = 5'd18,
    ST_JB1     = 5'd19,
    ST_JB2     = 5'd20,
    ST_JB3     = 5'd21,
    ST_JB4     = 5'd22,
    ST_JB5     = 5'd23,
    ST_OUT1    = 5'd24,
    ST_ILLEGAL = 5'd25
  } state_t;

  // Every datapath control line, in one word
  typedef struct packed {
    logic [1:0] aluOp;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] memtoReg;
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic [1:0] iorD;
    logic       irWrite;
    logic       pcWrite;
    logic       jump;
    logic [1:0] branch;
    logic       shouldBranch;
    logic [1:0] regFileSrc;
    logic [2:0] returnSrc;
    logic [1:0] dataSrc;
    logic [1:0] operandSrc;
    logic       spWrite;
    logic       instrDone;
    logic       illegalOp;
  } ctrl_t;

  // First execute state for an opcode seen during DECODE
  function automatic state_t firstState(logic [4:0] op);
    case (op)
      OP_MOVESP: return ST_MS1;
      OP_INPUT:  return ST_IN1;
      OP_JAL:    return ST_J1;
      OP_LOADSP: return ST_L1;
      OP_ADDI:   return ST_AD1;
      OP_SWAP:   return ST_SW1;
      OP_JB:     return ST_JB1;
      OP_OUTPUT: return ST_OUT1;
      default:   return ST_ILLEGAL;
    endcase
  endfunction

  // Opcode that owns an execute state: {valid, opcode}
  function automatic logic [5:0] seqOpcode(state_t s);
    case (s)
      ST_MS1, ST_MS2:                         return {1'b1, OP_MOVESP};
      ST_IN1, ST_IN2:                         return {1'b1, OP_INPUT};
      ST_J1, ST_J2, ST_J3, ST_J4, ST_J5:      return {1'b1, OP_JAL};
      ST_L1, ST_L2, ST_L3:                    return {1'b1, OP_LOADSP};
      ST_AD1, ST_AD2:                         return {1'b1, OP_ADDI};
      ST_SW1, ST_SW2:                         return {1'b1, OP_SWAP};
      ST_JB1, ST_JB2, ST_JB3, ST_JB4, ST_JB5: return {1'b1, OP_JB};
      ST_OUT1:                                return {1'b1, OP_OUTPUT};
      default:                                return 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/control_decode.sv
// Pure combinational state-to-control-word ROM (Moore outputs).
module control_decode
  import control_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  // Decode the current state into every control line; unlisted lines stay 0
  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.pcWrite = 1'b1; ctrl.iorD = IORD_PC; ctrl.memRead = 1'b1;
        ctrl.aluSrcA = 2'b00; ctrl.aluSrcB = 2'b11; ctrl.aluOp = ALUOP_ADD;
      end
      ST_DECODE: begin
        ctrl.irWrite = 1'b1; ctrl.iorD = IORD_MDR; ctrl.memRead = 1'b1;
        ctrl.aluSrcA = 2'b00; ctrl.aluSrcB = 2'b01; ctrl.aluOp = ALUOP_ADD;
      end
      ST_MS1, ST_IN1, ST_L1: begin
        ctrl.aluSrcA = 2'b11; ctrl.aluSrcB = 2'b01; ctrl.aluOp = ALUOP_FUNC;
      end
      ST_MS2: begin
        ctrl.spWrite = 1'b1; ctrl.instrDone = 1'b1;
      end
      ST_IN2: begin
        ctrl.memWrite = 1'b1; ctrl.dataSrc = 2'b10; ctrl.iorD = IORD_ALUOUT;
        ctrl.instrDone = 1'b1;
      end
      ST_J1: begin
        ctrl.aluSrcA = 2'b11; ctrl.aluSrcB = 2'b11; ctrl.aluOp = ALUOP_FUNC;
      end
      ST_J2, ST_J3, ST_J4: begin
        ctrl.memWrite = 1'b1; ctrl.iorD = IORD_ALUOUT;
        ctrl.aluSrcA = 2'b01; ctrl.aluSrcB = 2'b11; ctrl.aluOp = ALUOP_FUNC;
        // Push order: operand 11 first, then 10, then 01
        ctrl.dataSrc    = (state == ST_J2) ? 2'b00 : 2'b01;
        ctrl.operandSrc = (state == ST_J2) ? 2'b11 : (state == ST_J3) ? 2'b10 : 2'b01;
      end
      ST_J5: begin
        ctrl.memWrite = 1'b1; ctrl.dataSrc = 2'b01; ctrl.iorD = IORD_ALUOUT;
        ctrl.spWrite = 1'b1; ctrl.pcWrite = 1'b1;
        ctrl.aluSrcA = 2'b00; ctrl.aluSrcB = 2'b01; ctrl.aluOp = ALUOP_ADD;
        ctrl.instrDone = 1'b1;
      end
      ST_L2: begin
        ctrl.iorD = IORD_ALUOUT; ctrl.memRead = 1'b1;
      end
      ST_L3: begin
        ctrl.regWrite = 1'b1; ctrl.regFileSrc = 2'b00; ctrl.returnSrc = 3'b000;
        ctrl.instrDone = 1'b1;
      end
      ST_AD1: begin
        ctrl.aluSrcA = 2'b10; ctrl.aluSrcB = 2'b01; ctrl.aluOp = ALUOP_FUNC;
      end
      ST_AD2: begin
        ctrl.regWrite = 1'b1; ctrl.regFileSrc = 2'b10; ctrl.returnSrc = 3'b000;
        ctrl.instrDone = 1'b1;
      end
      ST_SW1: begin
        ctrl.aluSrcA = 2'b10; ctrl.aluOp = ALUOP_FUNC;
        ctrl.regFileSrc = 2'b01; ctrl.regWrite = 1'b1; ctrl.returnSrc = 3'b000;
      end
      ST_SW2: begin
        ctrl.regWrite = 1'b1; ctrl.regFileSrc = 2'b10; ctrl.returnSrc = 3'b010;
        ctrl.instrDone = 1'b1;
      end
      ST_JB1: begin
        ctrl.memRead = 1'b1; ctrl.iorD = IORD_SP;
        ctrl.aluSrcA = 2'b11; ctrl.aluSrcB = 2'b11; ctrl.aluOp = ALUOP_FUNC;
      end
      ST_JB2, ST_JB3, ST_JB4: begin
        ctrl.regWrite = 1'b1; ctrl.regFileSrc = 2'b00; ctrl.iorD = IORD_ALUOUT;
        ctrl.aluSrcA = 2'b01; ctrl.aluSrcB = 2'b11; ctrl.aluOp = ALUOP_FUNC;
        // Pop order: register 5, then 4, then 3
        ctrl.returnSrc = (state == ST_JB2) ? 3'b101 : (state == ST_JB3) ? 3'b100 : 3'b011;
      end
      ST_JB5: begin
        ctrl.branch = 2'b10; ctrl.jump = 1'b1; ctrl.spWrite = 1'b1;
        ctrl.instrDone = 1'b1;
      end
      ST_OUT1: begin
        // Datapath drives Outputio by itself; only mark the instruction done
        ctrl.instrDone = 1'b1;
      end
      ST_ILLEGAL: begin
        ctrl.illegalOp = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multicycle fetch/decode/execute control unit driving the datapath control lines.
module control_fsm
  import control_pkg::*;
#(
  parameter int OPCODE_W = 5,
  parameter int STATE_W  = 5
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic [OPCODE_W-1:0] Opcode,
  output logic [1:0]          ALUOp,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          MemtoReg,
  output logic                RegWrite,
  output logic                MemRead,
  output logic                MemWrite,
  output logic [1:0]          IorD,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                Jump,
  output logic [1:0]          Branch,
  output logic                shouldBranch,
  output logic [1:0]          RegFileSrc,
  output logic [2:0]          ReturnSrc,
  output logic [1:0]          DataSrc,
  output logic [1:0]          OperandSrc,
  output logic                SPWrite,
  output logic                InstrDone,
  output logic                IllegalOp,
  output logic [STATE_W-1:0]  State
);

  state_t              stateReg, stateNext;
  logic [OPCODE_W-1:0] opQ;
  ctrl_t               ctrl;
  logic [5:0]          seqInfo;

  // State and latched-opcode registers; reset abandons any instruction in flight
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      stateReg <= ST_INIT;
      opQ      <= '0;
    end else begin
      stateReg <= stateNext;
      if (stateReg == ST_DECODE) opQ <= Opcode;
    end
  end

  // Next state: execute sequences advance unconditionally, only DECODE looks at Opcode
  always_comb begin
    stateNext = ST_FETCH;
    case (stateReg)
      ST_INIT:   stateNext = ST_FETCH;
      ST_FETCH:  stateNext = ST_DECODE;
      ST_DECODE: stateNext = firstState(5'(Opcode));
      ST_MS1:    stateNext = ST_MS2;
      ST_IN1:    stateNext = ST_IN2;
      ST_J1:     stateNext = ST_J2;
      ST_J2:     stateNext = ST_J3;
      ST_J3:     stateNext = ST_J4;
      ST_J4:     stateNext = ST_J5;
      ST_L1:     stateNext = ST_L2;
      ST_L2:     stateNext = ST_L3;
      ST_AD1:    stateNext = ST_AD2;
      ST_SW1:    stateNext = ST_SW2;
      ST_JB1:    stateNext = ST_JB2;
      ST_JB2:    stateNext = ST_JB3;
      ST_JB3:    stateNext = ST_JB4;
      ST_JB4:    stateNext = ST_JB5;
      default:   stateNext = ST_FETCH;
    endcase
  end

  control_decode uDecode (
    .state (stateReg),
    .ctrl  (ctrl)
  );

  assign ALUOp        = ctrl.aluOp;
  assign ALUSrcA      = ctrl.aluSrcA;
  assign ALUSrcB      = ctrl.aluSrcB;
  assign MemtoReg     = ctrl.memtoReg;
  assign RegWrite     = ctrl.regWrite;
  assign MemRead      = ctrl.memRead;
  assign MemWrite     = ctrl.memWrite;
  assign IorD         = ctrl.iorD;
  assign IRWrite      = ctrl.irWrite;
  assign PCWrite      = ctrl.pcWrite;
  assign Jump         = ctrl.jump;
  assign Branch       = ctrl.branch;
  assign shouldBranch = ctrl.shouldBranch;
  assign RegFileSrc   = ctrl.regFileSrc;
  assign ReturnSrc    = ctrl.returnSrc;
  assign DataSrc      = ctrl.dataSrc;
  assign OperandSrc   = ctrl.operandSrc;
  assign SPWrite      = ctrl.spWrite;
  assign InstrDone    = ctrl.instrDone;
  assign IllegalOp    = ctrl.illegalOp;
  assign State        = STATE_W'(stateReg);

  // The latched opcode must always own the execute state we are in
  assign seqInfo = seqOpcode(stateReg);
  assert property (@(posedge CLK) disable iff (Reset)
    seqInfo[5] |-> (opQ == OPCODE_W'(seqInfo[4:0])));

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: per-state control words, latencies, illegal ops, async reset.
module tb_control_fsm;
  import control_pkg::*;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic [4:0] Opcode = 5'h00;
  logic [1:0] ALUOp, ALUSrcA, ALUSrcB, MemtoReg, IorD, Branch, RegFileSrc, DataSrc, OperandSrc;
  logic       RegWrite, MemRead, MemWrite, IRWrite, PCWrite, Jump, shouldBranch;
  logic       SPWrite, InstrDone, IllegalOp;
  logic [2:0] ReturnSrc;
  logic [4:0] State;

  control_fsm #(.OPCODE_W(5), .STATE_W(5)) dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .Jump(Jump), .Branch(Branch),
    .shouldBranch(shouldBranch), .RegFileSrc(RegFileSrc), .ReturnSrc(ReturnSrc),
    .DataSrc(DataSrc), .OperandSrc(OperandSrc), .SPWrite(SPWrite),
    .InstrDone(InstrDone), .IllegalOp(IllegalOp), .State(State)
  );

  always #5 CLK = ~CLK;

  // Observed control word, packed in a fixed field order
  typedef struct packed {
    logic [1:0] aluOp, srcA, srcB, memtoReg;
    logic       regWrite, memRead, memWrite;
    logic [1:0] iorD;
    logic       irWrite, pcWrite, jump;
    logic [1:0] branch;
    logic       shouldBranch;
    logic [1:0] regFileSrc;
    logic [2:0] returnSrc;
    logic [1:0] dataSrc, operandSrc;
    logic       spWrite, instrDone, illegalOp;
  } sigT;

  sigT obs;
  assign obs = {ALUOp, ALUSrcA, ALUSrcB, MemtoReg, RegWrite, MemRead, MemWrite, IorD,
                IRWrite, PCWrite, Jump, Branch, shouldBranch, RegFileSrc, ReturnSrc,
                DataSrc, OperandSrc, SPWrite, InstrDone, IllegalOp};

  int cmpCount = 0;
  int errCount = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    cmpCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Hand-written expected control word per state
  function automatic sigT expSigs(input state_t s);
    sigT e;
    e = '0;
    case (s)
      ST_FETCH:   begin e.pcWrite=1; e.memRead=1; e.srcB=2'b11; end
      ST_DECODE:  begin e.irWrite=1; e.iorD=2'b01; e.memRead=1; e.srcB=2'b01; end
      ST_MS1, ST_IN1, ST_L1: begin e.srcA=2'b11; e.srcB=2'b01; e.aluOp=2'b10; end
      ST_MS2:     begin e.spWrite=1; e.instrDone=1; end
      ST_IN2:     begin e.memWrite=1; e.dataSrc=2'b10; e.iorD=2'b10; e.instrDone=1; end
      ST_J1:      begin e.srcA=2'b11; e.srcB=2'b11; e.aluOp=2'b10; end
      ST_J2:      begin e.memWrite=1; e.iorD=2'b10; e.srcA=2'b01; e.srcB=2'b11; e.aluOp=2'b10;
                        e.dataSrc=2'b00; e.operandSrc=2'b11; end
      ST_J3:      begin e.memWrite=1; e.iorD=2'b10; e.srcA=2'b01; e.srcB=2'b11; e.aluOp=2'b10;
                        e.dataSrc=2'b01; e.operandSrc=2'b10; end
      ST_J4:      begin e.memWrite=1; e.iorD=2'b10; e.srcA=2'b01; e.srcB=2'b11; e.aluOp=2'b10;
                        e.dataSrc=2'b01; e.operandSrc=2'b01; end
      ST_J5:      begin e.memWrite=1; e.dataSrc=2'b01; e.iorD=2'b10; e.spWrite=1; e.pcWrite=1;
                        e.srcB=2'b01; e.instrDone=1; end
      ST_L2:      begin e.iorD=2'b10; e.memRead=1; end
      ST_L3:      begin e.regWrite=1; e.instrDone=1; end
      ST_AD1:     begin e.srcA=2'b10; e.srcB=2'b01; e.aluOp=2'b10; end
      ST_AD2:     begin e.regWrite=1; e.regFileSrc=2'b10; e.instrDone=1; end
      ST_SW1:     begin e.srcA=2'b10; e.aluOp=2'b10; e.regFileSrc=2'b01; e.regWrite=1; end
      ST_SW2:     begin e.regWrite=1; e.regFileSrc=2'b10; e.returnSrc=3'b010; e.instrDone=1; end
      ST_JB1:     begin e.memRead=1; e.iorD=2'b11; e.srcA=2'b11; e.srcB=2'b11; e.aluOp=2'b10; end
      ST_JB2:     begin e.regWrite=1; e.returnSrc=3'b101; e.iorD=2'b10; e.srcA=2'b01; e.srcB=2'b11; e.aluOp=2'b10; end
      ST_JB3:     begin e.regWrite=1; e.returnSrc=3'b100; e.iorD=2'b10; e.srcA=2'b01; e.srcB=2'b11; e.aluOp=2'b10; end
      ST_JB4:     begin e.regWrite=1; e.returnSrc=3'b011; e.iorD=2'b10; e.srcA=2'b01; e.srcB=2'b11; e.aluOp=2'b10; end
      ST_JB5:     begin e.branch=2'b10; e.jump=1; e.spWrite=1; e.instrDone=1; end
      ST_OUT1:    begin e.instrDone=1; end
      ST_ILLEGAL: begin e.illegalOp=1; end
      default:    e = '0;
    endcase
    return e;
  endfunction

  state_t expSeq [8];
  int     expN;

  // Expected execute-state sequence for an opcode
  task automatic setSeq(input logic [4:0] op);
    expN = 0;
    case (op)
      OP_MOVESP: begin expSeq[0]=ST_MS1; expSeq[1]=ST_MS2; expN=2; end
      OP_INPUT:  begin expSeq[0]=ST_IN1; expSeq[1]=ST_IN2; expN=2; end
      OP_JAL:    begin expSeq[0]=ST_J1; expSeq[1]=ST_J2; expSeq[2]=ST_J3; expSeq[3]=ST_J4;
                       expSeq[4]=ST_J5; expN=5; end
      OP_LOADSP: begin expSeq[0]=ST_L1; expSeq[1]=ST_L2; expSeq[2]=ST_L3; expN=3; end
      OP_ADDI:   begin expSeq[0]=ST_AD1; expSeq[1]=ST_AD2; expN=2; end
      OP_SWAP:   begin expSeq[0]=ST_SW1; expSeq[1]=ST_SW2; expN=2; end
      OP_JB:     begin expSeq[0]=ST_JB1; expSeq[1]=ST_JB2; expSeq[2]=ST_JB3; expSeq[3]=ST_JB4;
                       expSeq[4]=ST_JB5; expN=5; end
      OP_OUTPUT: begin expSeq[0]=ST_OUT1; expN=1; end
      default:   begin expSeq[0]=ST_ILLEGAL; expN=1; end
    endcase
  endtask

  // Runs one instruction starting in FETCH; Opcode is scrambled during execute states
  task automatic runInstr(input logic [4:0] op, input string name, input int expLen,
                          input int expDone, input int expIll);
    int cycles, doneCnt, illCnt;
    state_t expS;
    setSeq(op);
    checkVal({name, " fetch state"}, 64'(State), 64'(ST_FETCH));
    checkVal({name, " fetch sigs"}, 64'(obs), 64'(expSigs(ST_FETCH)));
    Opcode = op;
    cycles = 1; doneCnt = 0; illCnt = 0;
    step();
    cycles++;
    checkVal({name, " decode state"}, 64'(State), 64'(ST_DECODE));
    checkVal({name, " decode sigs"}, 64'(obs), 64'(expSigs(ST_DECODE)));
    step();
    for (int i = 0; i < 12; i++) begin
      if (State == 5'(ST_FETCH)) break;
      Opcode = (i % 2 == 0) ? (op ^ 5'h1F) : OP_JAL;
      expS = (i < expN) ? expSeq[i] : ST_FETCH;
      checkVal($sformatf("%s exec%0d state", name, i), 64'(State), 64'(expS));
      checkVal($sformatf("%s exec%0d sigs", name, i), 64'(obs), 64'(expSigs(expS)));
      if (InstrDone) doneCnt++;
      if (IllegalOp) illCnt++;
      step();
      cycles++;
    end
    checkVal({name, " latency"}, 64'(cycles), 64'(expLen));
    checkVal({name, " instrDone count"}, 64'(doneCnt), 64'(expDone));
    checkVal({name, " illegalOp count"}, 64'(illCnt), 64'(expIll));
    $display("instr %s op=%02h cycles=%0d done=%0d illegal=%0d", name, op, cycles, doneCnt, illCnt);
  endtask

  initial begin
    // Reset held for 3 cycles
    #1;
    checkVal("reset state", 64'(State), 64'(ST_INIT));
    checkVal("reset sigs", 64'(obs), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkVal($sformatf("reset hold%0d state", i), 64'(State), 64'(ST_INIT));
      checkVal($sformatf("reset hold%0d sigs", i), 64'(obs), 64'd0);
    end
    Reset = 1'b0;
    #1;
    checkVal("post-release init", 64'(State), 64'(ST_INIT));
    step();

    runInstr(OP_JAL,    "JAL",    7, 1, 0);
    runInstr(OP_JB,     "JB",     7, 1, 0);
    runInstr(OP_MOVESP, "MOVESP", 4, 1, 0);
    runInstr(OP_INPUT,  "INPUT",  4, 1, 0);
    runInstr(OP_LOADSP, "LOADSP", 5, 1, 0);
    runInstr(OP_ADDI,   "ADDI",   4, 1, 0);
    runInstr(OP_SWAP,   "SWAP",   4, 1, 0);
    runInstr(OP_OUTPUT, "OUTPUT", 3, 1, 0);
    runInstr(5'h00,     "ILL00",  3, 0, 1);
    runInstr(5'h15,     "ILL15",  3, 0, 1);

    // Asynchronous reset in the middle of JAL (J3)
    checkVal("jal2 fetch", 64'(State), 64'(ST_FETCH));
    Opcode = OP_JAL;
    step(); step(); step(); step();
    checkVal("jal2 in J3", 64'(State), 64'(ST_J3));
    #2;
    Reset = 1'b1;
    #1;
    checkVal("async reset state", 64'(State), 64'(ST_INIT));
    checkVal("async reset sigs", 64'(obs), 64'd0);
    checkVal("async reset opQ", 64'(dut.opQ), 64'd0);
    $display("async reset mid-JAL state=%0d", State);
    step(); step();
    Reset = 1'b0;
    #1;
    checkVal("release init", 64'(State), 64'(ST_INIT));
    step();
    runInstr(OP_ADDI,   "ADDI-after-reset", 4, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
- Multicycle control unit: the other end of the control-signal interface driven into headless_machine.
- Runs a fetch/decode/execute state machine.
- Drives every datapath control line from the instruction opcode.
- Sits beside headless_machine in the top-level processor and replaces bench-driven control.

Parameters:
OPCODE_W, 5, opcode field width (instruction bits [4:0])
STATE_W, 5, state register width (debug port width)

Ports:
CLK  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
Opcode  input  OPCODE_W  memory read-data bits [4:0] (value being loaded into IR during DECODE)
ALUOp  output  2  ALU operation select
ALUSrcA  output  2  ALU A mux
ALUSrcB  output  2  ALU B mux
MemtoReg  output  2  tied 00 in every state
RegWrite  output  1  register file write
MemRead  output  1  memory read
MemWrite  output  1  memory write
IorD  output  2  memory address select
IRWrite  output  1  instruction register write
PCWrite  output  1  PC write
Jump  output  1  jump select
Branch  output  2  PC-source select
shouldBranch  output  1  tied 0 in every state
RegFileSrc  output  2  register write-data select
ReturnSrc  output  3  register write-index select
DataSrc  output  2  memory write-data select
OperandSrc  output  2  register read-index select
SPWrite  output  1  stack pointer write
InstrDone  output  1  one-cycle pulse in the last execute state of each instruction
IllegalOp  output  1  one-cycle pulse in the cycle after DECODE for an unsupported opcode
State  output  STATE_W  current state encoding, debug only

Behaviour:
- Moore machine: all outputs decode combinationally from the state register; only the state and op_q are flops.
- Reset asserted: state=INIT and op_q=0 immediately. In INIT every output is 0, and State reads INIT.
- Reset mid-instruction abandons the instruction with no partial-write hold.
- INIT -> FETCH on the first edge after Reset deasserts.
- Any signal not listed for a state is 0.
- FETCH: PCWrite=1, IorD=00, MemRead=1, ALUSrcA=00, ALUSrcB=11, ALUOp=00. Next state DECODE.
- DECODE: IRWrite=1, IorD=01, MemRead=1, ALUSrcA=00, ALUSrcB=01, ALUOp=00.
  - op_q <= Opcode on the DECODE edge.
  - Next state is chosen from Opcode on that same edge.
- Per-opcode execute sequences, with register-write and SP fields:
  - MOVESP 0x19:
    - MS1: A=11, B=01, Op=10.
    - MS2: SPWrite=1.
  - INPUT 0x1A:
    - IN1: A=11, B=01, Op=10.
    - IN2: MemWrite=1, DataSrc=10, IorD=10.
  - JAL 0x14:
    - J1: A=11, B=11, Op=10.
    - J2: MemWrite=1, DataSrc=00, IorD=10, A=01, B=11, Op=10, OperandSrc=11.
    - J3: as J2 but DataSrc=01, OperandSrc=10.
    - J4: as J3 but OperandSrc=01.
    - J5: MemWrite=1, DataSrc=01, IorD=10, SPWrite=1, PCWrite=1, A=00, B=01, Op=00.
  - LOADSP 0x1F:
    - L1: A=11, B=01, Op=10.
    - L2: IorD=10, MemRead=1.
    - L3: RegWrite=1, RegFileSrc=00, ReturnSrc=000.
  - ADDI 0x18:
    - AD1: A=10, B=01, Op=10.
    - AD2: RegWrite=1, RegFileSrc=10, ReturnSrc=000.
  - SWAP 0x0B:
    - SW1: A=10, Op=10, RegFileSrc=01, RegWrite=1, ReturnSrc=000.
    - SW2: RegWrite=1, RegFileSrc=10, ReturnSrc=010.
  - JB 0x1D:
    - JB1: MemRead=1, IorD=11, A=11, B=11, Op=10.
    - JB2: RegWrite=1, RegFileSrc=00, ReturnSrc=101, IorD=10, A=01, B=11, Op=10.
    - JB3: as JB2 with ReturnSrc=100.
    - JB4: as JB2 with ReturnSrc=011.
    - JB5: Branch=10, Jump=1, SPWrite=1.
  - OUTPUT 0x1C:
    - OUT1: all outputs 0; the datapath presents Outputio combinationally.
- Within a sequence states advance unconditionally, one per cycle.
- The last state of every sequence asserts InstrDone and returns to FETCH.
- Latency (FETCH to next FETCH):
  - 3 cycles: OUTPUT.
  - 4 cycles: MOVESP, INPUT, ADDI, SWAP.
  - 5 cycles: LOADSP.
  - 7 cycles: JAL, JB.
- Unsupported opcode: DECODE -> ILLEGAL for one cycle (IllegalOp=1, all else 0), then FETCH. The machine never stalls.
- Opcode changes outside DECODE have no effect. Execute states depend only on state.
- Unused state encodings return to FETCH on the next edge, with outputs 0.

Decomposition:
- Shared package control_pkg holds:
  - opcode constants (OP_MOVESP=5'h19, OP_INPUT=5'h1A, OP_JAL=5'h14, OP_LOADSP=5'h1F, OP_ADDI=5'h18, OP_SWAP=5'h0B, OP_JB=5'h1D, OP_OUTPUT=5'h1C);
  - the state enum;
  - mux-select constants (ALUOP_ADD=00, ALUOP_FUNC=10, IORD_PC=00, IORD_MDR=01, IORD_ALUOUT=10, IORD_SP=11).
- One sub-module is natural: control_decode, a pure combinational state-to-signal ROM.
- control_fsm keeps the state and op_q registers plus the next-state logic.

Test Plan:
- Reset held 3 cycles, then released: all outputs 0 with State=INIT during reset; next cycle FETCH with PCWrite=1, MemRead=1, ALUSrcB=11; then DECODE with IRWrite=1, IorD=01.
- Opcode=0x14 at DECODE: J1..J5 outputs match the table. In J5, SPWrite=PCWrite=MemWrite=1 and InstrDone=1. FETCH follows exactly 7 cycles after the prior FETCH.
- Opcode=0x1D: JB2/JB3/JB4 show ReturnSrc 101/100/011 with RegWrite=1; JB5 Branch=10, Jump=1, SPWrite=1.
- Program stream 0x19, 0x1A, 0x1F, 0x18, 0x0B, 0x1C: cycle counts 4, 4, 5, 4, 4, 3 between FETCHes. Exactly one InstrDone per instruction.
- Opcode=0x00 at DECODE: one ILLEGAL cycle with IllegalOp=1 and no write enables, then FETCH. Opcode toggled during execute states leaves the sequence unchanged.
- Reset asserted asynchronously mid-JAL (in J3): outputs go to 0 within the same cycle, with no clock edge needed. After release, resumes at FETCH with op_q=0.
